// File: rtl/top_pkg.sv
// Shared definitions for the 6502-subset CPU: memory map, reset vector,
// opcode constants, FSM state encoding and decoded-instruction record.
package top_pkg;

    // Memory map
    localparam logic [15:0] RAM_BASE      = 16'h0000;
    localparam int          RAM_SIZE      = 2048;
    localparam logic [15:0] ROM_BASE      = 16'hF000;
    localparam int          ROM_SIZE      = 4096;
    localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

    // Reset vector (low byte, then high byte)
    localparam logic [15:0] RESET_VEC_LO = 16'hFFFC;
    localparam logic [15:0] RESET_VEC_HI = 16'hFFFD;

    // Loads
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
    localparam logic [7:0] OP_LDX_ZP  = 8'hA6;
    localparam logic [7:0] OP_LDY_ZP  = 8'hA4;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_LDX_ABS = 8'hAE;
    localparam logic [7:0] OP_LDY_ABS = 8'hAC;
    // Stores
    localparam logic [7:0] OP_STA_ZP  = 8'h85;
    localparam logic [7:0] OP_STX_ZP  = 8'h86;
    localparam logic [7:0] OP_STY_ZP  = 8'h84;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_STX_ABS = 8'h8E;
    localparam logic [7:0] OP_STY_ABS = 8'h8C;
    // Jump
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    // Indexed forms (only decoded when the indexed option is built in)
    localparam logic [7:0] OP_LDA_ABX = 8'hBD;
    localparam logic [7:0] OP_STA_ABX = 8'h9D;
    localparam logic [7:0] OP_LDA_ABY = 8'hB9;
    localparam logic [7:0] OP_STA_ABY = 8'h99;
    localparam logic [7:0] OP_LDA_ZPX = 8'hB5;
    localparam logic [7:0] OP_STA_ZPX = 8'h95;

    // CPU sequencer states; one memory access per state visit
    typedef enum logic [2:0] {
        RST_LO = 3'd0,
        RST_HI = 3'd1,
        FETCH  = 3'd2,
        OP1    = 3'd3,
        OP2    = 3'd4,
        EXEC   = 3'd5
    } state_e;

    // Addressing mode after decode; M_NOP covers every unsupported opcode
    typedef enum logic [2:0] {
        M_NOP = 3'd0,
        M_IMM = 3'd1,
        M_ZP  = 3'd2,
        M_ABS = 3'd3,
        M_JMP = 3'd4,
        M_ZPX = 3'd5,
        M_ABX = 3'd6,
        M_ABY = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        R_A = 2'd0,
        R_X = 2'd1,
        R_Y = 2'd2
    } reg_e;

    typedef struct packed {
        mode_e mode;
        reg_e  rsel;
        logic  store;
    } op_info_t;

endpackage

// File: rtl/top_mem.sv
// mem: 4 KiB ROM at the top of the map, 2 KiB RAM at the bottom, address
// decode and combinational read mux. ROM has no CPU write path; its contents
// are placed hierarchically (top.mem.ROM[]). Unmapped reads return $FF.
module mem
    import top_pkg::*;
#(
    parameter int ROM_AW = 12,
    parameter int RAM_AW = 11
) (
    input  logic        clk,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata
);

    localparam int ROM_DEPTH = 1 << ROM_AW;
    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [7:0] ROM [0:ROM_DEPTH-1];
    logic [7:0] RAM [0:RAM_DEPTH-1];

    logic ram_sel;
    logic rom_sel;

    // Region decode and combinational read data
    always_comb begin
        ram_sel = (addr[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
        rom_sel = (addr[15:ROM_AW] == ROM_BASE[15:ROM_AW]);
        if (ram_sel) begin
            rdata = RAM[addr[RAM_AW-1:0]];
        end else if (rom_sel) begin
            rdata = ROM[addr[ROM_AW-1:0]];
        end else begin
            rdata = UNMAPPED_DATA;
        end
    end

    // RAM write port; writes to ROM or unmapped space are dropped
    always_ff @(posedge clk) begin
        if (we && ram_sel) begin
            RAM[addr[RAM_AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/top.sv
// top: 6502-subset CPU (A, X, Y, N/Z flags, 16-bit PC) driving the mem block.
// Optional feature: define TOP_INDEXED_EN to add LDA/STA abs,X, abs,Y and zp,X;
// without it those opcodes fall into the 2-cycle NOP path.
module top
    import top_pkg::*;
#(
    parameter int ROM_AW = 12,
    parameter int RAM_AW = 11
) (
    input logic ph1,
    input logic reset,
    input logic ph2
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] ea_q, ea_d;
    logic        fix_q, fix_d;   // indexed store: one dummy read before the write
    logic [7:0]  a_q, a_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic        n_q, n_d;
    logic        z_q, z_d;

    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        mem_we;

    op_info_t    info;
    logic [7:0]  reg_val;
    logic [7:0]  idx_val;
    logic        ld_en;

    logic        unused_ph2;
    assign unused_ph2 = ph2;

    // A write is never allowed to land while reset is held
    assign mem_we = bus_we & ~reset;

    function automatic op_info_t decode_op(input logic [7:0] op);
        op_info_t d;
        d.mode  = M_NOP;
        d.rsel  = R_A;
        d.store = 1'b0;
        case (op)
            OP_LDA_IMM: begin d.mode = M_IMM; d.rsel = R_A; end
            OP_LDX_IMM: begin d.mode = M_IMM; d.rsel = R_X; end
            OP_LDY_IMM: begin d.mode = M_IMM; d.rsel = R_Y; end
            OP_LDA_ZP:  begin d.mode = M_ZP;  d.rsel = R_A; end
            OP_LDX_ZP:  begin d.mode = M_ZP;  d.rsel = R_X; end
            OP_LDY_ZP:  begin d.mode = M_ZP;  d.rsel = R_Y; end
            OP_LDA_ABS: begin d.mode = M_ABS; d.rsel = R_A; end
            OP_LDX_ABS: begin d.mode = M_ABS; d.rsel = R_X; end
            OP_LDY_ABS: begin d.mode = M_ABS; d.rsel = R_Y; end
            OP_STA_ZP:  begin d.mode = M_ZP;  d.rsel = R_A; d.store = 1'b1; end
            OP_STX_ZP:  begin d.mode = M_ZP;  d.rsel = R_X; d.store = 1'b1; end
            OP_STY_ZP:  begin d.mode = M_ZP;  d.rsel = R_Y; d.store = 1'b1; end
            OP_STA_ABS: begin d.mode = M_ABS; d.rsel = R_A; d.store = 1'b1; end
            OP_STX_ABS: begin d.mode = M_ABS; d.rsel = R_X; d.store = 1'b1; end
            OP_STY_ABS: begin d.mode = M_ABS; d.rsel = R_Y; d.store = 1'b1; end
            OP_JMP_ABS: begin d.mode = M_JMP; end
`ifdef TOP_INDEXED_EN
            OP_LDA_ABX: begin d.mode = M_ABX; end
            OP_STA_ABX: begin d.mode = M_ABX; d.store = 1'b1; end
            OP_LDA_ABY: begin d.mode = M_ABY; end
            OP_STA_ABY: begin d.mode = M_ABY; d.store = 1'b1; end
            OP_LDA_ZPX: begin d.mode = M_ZPX; end
            OP_STA_ZPX: begin d.mode = M_ZPX; d.store = 1'b1; end
`endif
            default: ;
        endcase
        return d;
    endfunction

    // Decode the latched opcode
    always_comb begin
        info = decode_op(op_q);
    end

    // Sequencer: next state, bus request and register updates for this cycle
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_d      = op_q;
        ea_d      = ea_q;
        fix_d     = fix_q;
        a_d       = a_q;
        x_d       = x_q;
        y_d       = y_q;
        n_d       = n_q;
        z_d       = z_q;
        bus_addr  = pc_q;
        bus_we    = 1'b0;
        bus_wdata = 8'h00;
        ld_en     = 1'b0;

        case (info.rsel)
            R_X:     reg_val = x_q;
            R_Y:     reg_val = y_q;
            default: reg_val = a_q;
        endcase
        idx_val = (info.mode == M_ABY) ? y_q : x_q;

        case (state_q)
            RST_LO: begin
                bus_addr = RESET_VEC_LO;
                pc_d     = {pc_q[15:8], bus_rdata};
                state_d  = RST_HI;
            end
            RST_HI: begin
                bus_addr = RESET_VEC_HI;
                pc_d     = {bus_rdata, pc_q[7:0]};
                state_d  = FETCH;
            end
            FETCH: begin
                op_d    = bus_rdata;
                pc_d    = pc_q + 16'd1;
                state_d = OP1;
            end
            OP1: begin
                case (info.mode)
                    M_NOP: begin
                        // Unsupported opcode: the operand byte is not consumed
                        state_d = FETCH;
                    end
                    M_IMM: begin
                        ld_en   = 1'b1;
                        pc_d    = pc_q + 16'd1;
                        state_d = FETCH;
                    end
                    M_ZP: begin
                        ea_d    = {8'h00, bus_rdata};
                        pc_d    = pc_q + 16'd1;
                        state_d = EXEC;
                    end
                    default: begin
                        ea_d    = {8'h00, bus_rdata};
                        pc_d    = pc_q + 16'd1;
                        state_d = OP2;
                    end
                endcase
            end
            OP2: begin
                case (info.mode)
                    M_JMP: begin
                        pc_d    = {bus_rdata, ea_q[7:0]};
                        state_d = FETCH;
                    end
                    M_ZPX: begin
                        // Dummy read of the base while the index is added in page 0
                        bus_addr = ea_q;
                        ea_d     = {8'h00, ea_q[7:0] + x_q};
                        state_d  = EXEC;
                    end
                    M_ABX, M_ABY: begin
                        ea_d    = {bus_rdata, ea_q[7:0]} + {8'h00, idx_val};
                        pc_d    = pc_q + 16'd1;
                        fix_d   = info.store;
                        state_d = EXEC;
                    end
                    M_ABS: begin
                        ea_d    = {bus_rdata, ea_q[7:0]};
                        pc_d    = pc_q + 16'd1;
                        state_d = EXEC;
                    end
                    default: begin
                        state_d = FETCH;
                    end
                endcase
            end
            EXEC: begin
                bus_addr = ea_q;
                if (fix_q) begin
                    fix_d = 1'b0;
                end else if (info.store) begin
                    bus_we    = 1'b1;
                    bus_wdata = reg_val;
                    state_d   = FETCH;
                end else begin
                    ld_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = RST_LO;
            end
        endcase

        if (ld_en) begin
            case (info.rsel)
                R_X:     x_d = bus_rdata;
                R_Y:     y_d = bus_rdata;
                default: a_d = bus_rdata;
            endcase
            n_d = bus_rdata[7];
            z_d = (bus_rdata == 8'h00);
        end
    end

    // Architectural and sequencer registers; reset aborts any instruction
    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q <= RST_LO;
            pc_q    <= '0;
            op_q    <= '0;
            ea_q    <= '0;
            fix_q   <= 1'b0;
            a_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            ea_q    <= ea_d;
            fix_q   <= fix_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    mem #(
        .ROM_AW (ROM_AW),
        .RAM_AW (RAM_AW)
    ) mem (
        .clk   (ph1),
        .addr  (bus_addr),
        .we    (mem_we),
        .wdata (bus_wdata),
        .rdata (bus_rdata)
    );

endmodule

// File: tb/tb_top.sv
// Bench for top: loads small ROM programs, tracks expected bus writes in a
// queue, and checks registers, flags, PC and memory at known cycle points.
module tb_top;
    import top_pkg::*;

    logic ph1;
    logic ph2;
    logic reset;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] prog[$];
    int         n_chk;
    int         n_pass;

    top dut (
        .ph1   (ph1),
        .reset (reset),
        .ph2   (ph2)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;
    assign ph2 = ~ph1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge ph1);
        @(negedge ph1);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        check("rst_a",  {24'h0, dut.a_q}, 32'h0);
        check("rst_x",  {24'h0, dut.x_q}, 32'h0);
        check("rst_y",  {24'h0, dut.y_q}, 32'h0);
        check("rst_nz", {30'h0, dut.n_q, dut.z_q}, 32'h0);
        check("rst_pc", {16'h0, dut.pc_q}, 32'h0);
        check("rst_st", 32'(dut.state_q), 32'(RST_LO));
        exp_q.delete();
    endtask

    task automatic load_prog();
        for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = 8'h00;
        dut.mem.ROM[12'hFFC] = 8'h00;
        dut.mem.ROM[12'hFFD] = 8'hF0;
        for (int i = 0; i < prog.size(); i++) dut.mem.ROM[i] = prog[i];
    endtask

    // Every write the CPU puts on the bus must match the next expected one
    always @(negedge ph1) begin
        if (dut.mem_we) begin
            check("wr_pending", {31'h0, exp_q.size() > 0}, 32'h1);
            if (exp_q.size() > 0) begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", {16'h0, dut.bus_addr}, {16'h0, w.addr});
                check("wr_data", {24'h0, dut.bus_wdata}, {24'h0, w.data});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        @(negedge ph1);

        // Basic store: LDA #$55; STA $022A; JMP self
        do_reset();
        prog = '{8'hA9, 8'h55, 8'h8D, 8'h2A, 8'h02, 8'h4C, 8'h05, 8'hF0};
        load_prog();
        push_wr(16'h022A, 8'h55);
        reset = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 170 && !found; c++) begin
            step(1);
            if (dut.mem.RAM[11'h22A] == 8'h55) found = 1'b1;
        end
        check("t1_in_time", {31'h0, found}, 32'h1);
        check("t1_ram", {24'h0, dut.mem.RAM[11'h22A]}, 32'h55);
        check("t1_a", {24'h0, dut.a_q}, 32'h55);
        check("t1_nz", {30'h0, dut.n_q, dut.z_q}, 32'h0);
        step(4);
        check("t1_left", exp_q.size(), 0);

        // LDX #$80; STX $10; LDY $10; JMP self
        do_reset();
        prog = '{8'hA2, 8'h80, 8'h86, 8'h10, 8'hA4, 8'h10, 8'h4C, 8'h06, 8'hF0};
        load_prog();
        push_wr(16'h0010, 8'h80);
        reset = 1'b0;
        step(7);
        check("t2_x", {24'h0, dut.x_q}, 32'h80);
        check("t2_nz", {30'h0, dut.n_q, dut.z_q}, 32'h2);
        check("t2_y_pre", {24'h0, dut.y_q}, 32'h0);
        check("t2_pc7", {16'h0, dut.pc_q}, 32'hF004);
        step(3);
        check("t2_y", {24'h0, dut.y_q}, 32'h80);
        check("t2_pc10", {16'h0, dut.pc_q}, 32'hF006);
        check("t2_ram", {24'h0, dut.mem.RAM[11'h010]}, 32'h80);
        check("t2_left", exp_q.size(), 0);

        // LDX #$80; LDA #0; LDA $F000; JMP self
        do_reset();
        prog = '{8'hA2, 8'h80, 8'hA9, 8'h00, 8'hAD, 8'h00, 8'hF0, 8'h4C, 8'h07, 8'hF0};
        load_prog();
        reset = 1'b0;
        step(6);
        check("t3_a0", {24'h0, dut.a_q}, 32'h0);
        check("t3_nz0", {30'h0, dut.n_q, dut.z_q}, 32'h1);
        check("t3_pc6", {16'h0, dut.pc_q}, 32'hF004);
        step(4);
        check("t3_a_rom", {24'h0, dut.a_q}, 32'hA2);
        check("t3_nz_rom", {30'h0, dut.n_q, dut.z_q}, 32'h2);
        check("t3_pc10", {16'h0, dut.pc_q}, 32'hF007);

        // LDA #$77; STA $F000; LDA $1234; JMP self
        do_reset();
        prog = '{8'hA9, 8'h77, 8'h8D, 8'h00, 8'hF0, 8'hAD, 8'h34, 8'h12, 8'h4C, 8'h08, 8'hF0};
        load_prog();
        push_wr(16'hF000, 8'h77);
        reset = 1'b0;
        step(20);
        check("t4_rom0", {24'h0, dut.mem.ROM[0]}, 32'hA9);
        check("t4_unmapped", {24'h0, dut.a_q}, 32'hFF);
        check("t4_nz", {30'h0, dut.n_q, dut.z_q}, 32'h2);
        check("t4_left", exp_q.size(), 0);

        // Reset in the third cycle of the second STA abs aborts it
        do_reset();
        prog = '{8'hA9, 8'hAA, 8'h8D, 8'h2A, 8'h02,
                 8'hA9, 8'h55, 8'h8D, 8'h2A, 8'h02, 8'h4C, 8'h0A, 8'hF0};
        load_prog();
        push_wr(16'h022A, 8'hAA);
        reset = 1'b0;
        step(12);
        check("t5_in_op2", 32'(dut.state_q), 32'(OP2));
        reset = 1'b1;
        step(2);
        check("t5_ram_kept", {24'h0, dut.mem.RAM[11'h22A]}, 32'hAA);
        check("t5_left", exp_q.size(), 0);
        push_wr(16'h022A, 8'hAA);
        push_wr(16'h022A, 8'h55);
        reset = 1'b0;
        step(2);
        check("t5_vec_pc", {16'h0, dut.pc_q}, 32'hF000);
        check("t5_vec_st", 32'(dut.state_q), 32'(FETCH));
        step(20);
        check("t5_ram_final", {24'h0, dut.mem.RAM[11'h22A]}, 32'h55);
        check("t5_left2", exp_q.size(), 0);

        // LDA #$11; STA $022A; LDX #2; LDA #$5A; STA $0228,X; JMP self
        do_reset();
        prog = '{8'hA9, 8'h11, 8'h8D, 8'h2A, 8'h02, 8'hA2, 8'h02, 8'hA9, 8'h5A,
                 8'h9D, 8'h28, 8'h02, 8'h4C, 8'h0C, 8'hF0};
        load_prog();
        push_wr(16'h022A, 8'h11);
`ifdef TOP_INDEXED_EN
        push_wr(16'h022A, 8'h5A);
`endif
        reset = 1'b0;
        step(30);
        check("t6_x", {24'h0, dut.x_q}, 32'h02);
        check("t6_a", {24'h0, dut.a_q}, 32'h5A);
`ifdef TOP_INDEXED_EN
        check("t6_ram", {24'h0, dut.mem.RAM[11'h22A]}, 32'h5A);
`else
        check("t6_ram", {24'h0, dut.mem.RAM[11'h22A]}, 32'h11);
`endif
        check("t6_left", exp_q.size(), 0);

        // Unsupported opcode $EA: 2 cycles, PC advances by one
        do_reset();
        prog = '{8'hEA, 8'hA9, 8'h33, 8'h4C, 8'h03, 8'hF0};
        load_prog();
        reset = 1'b0;
        step(4);
        check("t7_nop_pc", {16'h0, dut.pc_q}, 32'hF001);
        check("t7_nop_a", {24'h0, dut.a_q}, 32'h0);
        step(2);
        check("t7_a", {24'h0, dut.a_q}, 32'h33);
        check("t7_pc", {16'h0, dut.pc_q}, 32'hF003);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
